// File: rtl/product_accumulator.sv
// Saturating group accumulator behind the 3x4 array multiplier.
// Sums N_TERMS products, then holds the result on a valid/ready port.
module product_accumulator #(
    parameter int PROD_W  = 7,
    parameter int ACC_W   = 12,
    parameter int N_TERMS = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    input  logic                           prod_valid,
    output logic                           prod_ready,
    input  logic [PROD_W-1:0]              prod_data,
    output logic                           acc_valid,
    input  logic                           acc_ready,
    output logic [ACC_W-1:0]               acc_data,
    output logic                           acc_sat,
    output logic [$clog2(N_TERMS+1)-1:0]   term_cnt
);

    localparam int CNT_W = $clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

    typedef enum logic [1:0] {
        ACCUM = 2'b01,
        HOLD  = 2'b10
    } state_t;

    state_t           state, state_n;
    logic [ACC_W-1:0] acc, acc_n;
    logic             sat, sat_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [ACC_W:0]   sum;

    // One guard bit above the accumulator flags overflow.
    always_comb sum = {1'b0, acc} + (ACC_W + 1)'(prod_data);

    always_comb begin
        state_n = state;
        acc_n   = acc;
        sat_n   = sat;
        cnt_n   = cnt;
        if (clear) begin
            state_n = ACCUM;
            acc_n   = '0;
            sat_n   = 1'b0;
            cnt_n   = '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (prod_valid) begin
                        acc_n = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
                        sat_n = sat | sum[ACC_W];
                        cnt_n = cnt + CNT_W'(1);
                        if (cnt == LAST) state_n = HOLD;
                    end
                end
                HOLD: begin
                    if (acc_ready) begin
                        state_n = ACCUM;
                        acc_n   = '0;
                        sat_n   = 1'b0;
                        cnt_n   = '0;
                    end
                end
                default: begin
                    state_n = ACCUM;
                    acc_n   = '0;
                    sat_n   = 1'b0;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
            acc   <= '0;
            sat   <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            sat   <= sat_n;
            cnt   <= cnt_n;
        end
    end

    assign prod_ready = (state == ACCUM);
    assign acc_valid  = (state == HOLD);
    assign acc_data   = acc;
    assign acc_sat    = sat;
    assign term_cnt   = cnt;

endmodule
